// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Packet-level round-robin arbiter that shares one uart_tx byte channel
// between N byte-stream requesters. A grant is held from the first byte of a
// packet until the byte flagged with req_last_i has been accepted, so packets
// never interleave on the serial line. After each packet an optional idle gap
// of gap_i cycles is inserted before the next arbitration.
//
// Ports
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   req_data_i   N packed bytes, requester k on bits [8k+7:8k]
//   req_valid_i  per-requester byte valid
//   req_last_i   per-requester last-byte-of-packet flag (qualified by valid)
//   req_ready_o  per-requester byte accepted (only the granted bit can be set)
//   out_data_o   byte towards uart_tx
//   out_valid_o  byte valid towards uart_tx
//   out_ready_i  uart_tx ready
//   gap_i        idle cycles inserted after each packet, 0 = no gap
//   grant_o      one-hot current grant, all-zero when nobody is granted
//   busy_o       high while a packet is in flight or the idle gap is running
//
// State machine
//   IDLE : arbitrate among valid requesters, rotating priority from last+1
//   XFER : combinational pass-through of the granted requester's stream
//   GAP  : count gap_i idle cycles, then return to IDLE
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int N     = 4,
  parameter int GAP_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N*8-1:0]     req_data_i,
  input  logic [N-1:0]       req_valid_i,
  input  logic [N-1:0]       req_last_i,
  output logic [N-1:0]       req_ready_o,
  output logic [7:0]         out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic [GAP_W-1:0]   gap_i,
  output logic [N-1:0]       grant_o,
  output logic               busy_o
);

  // Index width for requester numbers; at least one bit even for tiny N.
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [N-1:0]       grant_reg;
  logic [IW-1:0]      gnt_idx_reg;   // binary form of grant_reg, drives the muxes
  logic [IW-1:0]      last_reg;      // most recently granted requester
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [GAP_W-1:0]   gap_lim_reg;   // gap_i captured when the packet ended
  logic               busy_reg;

  // ---------------------------------------------------------------------------
  // Round-robin winner search: first valid requester starting at last+1,
  // wrapping modulo N. The requester just served is checked last.
  // ---------------------------------------------------------------------------
  logic               win_found;
  logic [IW-1:0]      win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      int cand;
      cand = (int'(last_reg) + i) % N;
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: only the granted requester is connected, and only in XFER.
  // Everything is forced to zero elsewhere so uart_tx sees a clean idle bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_o  = '0;
    out_valid_o = 1'b0;
    req_ready_o = '0;
    if (state_reg == S_XFER) begin
      out_data_o               = req_data_i[gnt_idx_reg*8 +: 8];
      out_valid_o              = req_valid_i[gnt_idx_reg];
      req_ready_o[gnt_idx_reg] = out_ready_i;
    end
  end

  // A byte moves when both sides of the output handshake are high.
  logic xfer_fire;
  logic xfer_last;

  assign xfer_fire = out_valid_o & out_ready_i;
  assign xfer_last = xfer_fire & req_last_i[gnt_idx_reg];

  // ---------------------------------------------------------------------------
  // Control FSM with registered grant/busy outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= S_IDLE;
      grant_reg   <= '0;
      gnt_idx_reg <= '0;
      last_reg    <= IW'(N - 1);   // so requester 0 has first priority
      gap_cnt_reg <= '0;
      gap_lim_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            state_reg   <= S_XFER;
            grant_reg   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            gnt_idx_reg <= win_idx;
            last_reg    <= win_idx;
            busy_reg    <= 1'b1;
          end
        end

        S_XFER: begin
          // A stalled or silent granted requester keeps the grant forever;
          // other requesters are only looked at again from IDLE.
          if (xfer_last) begin
            grant_reg <= '0;
            if (gap_i != '0) begin
              state_reg   <= S_GAP;
              gap_lim_reg <= gap_i;
              gap_cnt_reg <= '0;
              busy_reg    <= 1'b1;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end

        S_GAP: begin
          // Leaving at limit-1 yields exactly gap_lim_reg cycles in GAP.
          if (gap_cnt_reg == gap_lim_reg - 1'b1) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = grant_reg;
  assign busy_o  = busy_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed testbench for uart_tx_arb (N=4, GAP_W=16). Inputs are driven 1 time
// unit after the rising edge and outputs are sampled 1 unit later, well away
// from the next active edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int N     = 4;
  localparam int GAP_W = 16;

  logic             clk_i;
  logic             rst_n_i;
  logic [N*8-1:0]   req_data_i;
  logic [N-1:0]     req_valid_i;
  logic [N-1:0]     req_last_i;
  logic [N-1:0]     req_ready_o;
  logic [7:0]       out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [GAP_W-1:0] gap_i;
  logic [N-1:0]     grant_o;
  logic             busy_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  uart_tx_arb #(.N(N), .GAP_W(GAP_W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .gap_i       (gap_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_data_i  = '0;
    req_valid_i = '0;
    req_last_i  = '0;
    out_ready_i = 1'b1;
    gap_i       = '0;
  endtask

  // Pulse reset, release it 1 unit after an edge; returns in IDLE at edge+1.
  task automatic do_reset();
    clear_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst_n_i = 1'b0;
    #3;
    chk_cnt++;
    if ({grant_o, busy_o, out_valid_o, out_data_o, req_ready_o} !== '0) begin
      $display("FAIL reset_values: got grant=%b busy=%b valid=%b data=%h ready=%b, want all 0",
               grant_o, busy_o, out_valid_o, out_data_o, req_ready_o);
    end else pass_cnt++;
    next_cycle();
    next_cycle();
    rst_n_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      #1;
      chk_cnt++;
      if ({grant_o, out_valid_o, busy_o} !== 6'b0) begin
        $display("FAIL idle_cycle%0d: got grant=%b valid=%b busy=%b, want 0/0/0",
                 c, grant_o, out_valid_o, busy_o);
      end else pass_cnt++;
    end
    $display("test_reset: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_packet();
    next_cycle();
    req_data_i[16 +: 8] = 8'h41;
    req_valid_i = 4'b0100;
    req_last_i  = 4'b0000;
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0000) $display("FAIL single_pre_grant: got %b want 0000", grant_o);
    else pass_cnt++;

    next_cycle();
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant_o);
    else pass_cnt++;
    chk_cnt++;
    if ({out_valid_o, out_data_o, req_ready_o} !== {1'b1, 8'h41, 4'b0100})
      $display("FAIL single_byte0: got valid=%b data=%h ready=%b want 1/41/0100",
               out_valid_o, out_data_o, req_ready_o);
    else pass_cnt++;

    next_cycle();
    req_data_i[16 +: 8] = 8'h42;
    #1;
    chk_cnt++;
    if (out_data_o !== 8'h42) $display("FAIL single_byte1: got %h want 42", out_data_o);
    else pass_cnt++;

    next_cycle();
    req_data_i[16 +: 8] = 8'h43;
    req_last_i = 4'b0100;
    #1;
    chk_cnt++;
    if ({out_valid_o, out_data_o, grant_o} !== {1'b1, 8'h43, 4'b0100})
      $display("FAIL single_byte2: got valid=%b data=%h grant=%b want 1/43/0100",
               out_valid_o, out_data_o, grant_o);
    else pass_cnt++;

    next_cycle();
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk_cnt++;
    if ({grant_o, busy_o, out_valid_o} !== 6'b0)
      $display("FAIL single_release: got grant=%b busy=%b valid=%b want 0/0/0",
               grant_o, busy_o, out_valid_o);
    else pass_cnt++;
    $display("test_single_packet: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int bc [N];
    int n;
    int exp_g;
    int pkt_bytes;
    logic [N-1:0] prev_grant;
    logic fire;
    do_reset();
    for (int k = 0; k < N; k++) bc[k] = 0;
    n = 0;
    exp_g = 0;
    pkt_bytes = 0;
    prev_grant = '0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (c > 0) next_cycle();
      for (int k = 0; k < N; k++) begin
        req_data_i[k*8 +: 8] = 8'(k * 16 + bc[k]);
        req_last_i[k]        = (bc[k] == 1);
      end
      req_valid_i = '1;
      #1;
      if (grant_o !== '0 && prev_grant === '0) begin
        exp_g = order[n];
        chk_cnt++;
        if (grant_o !== 4'(1 << exp_g))
          $display("FAIL rr_grant%0d: got %b want %b", n, grant_o, 4'(1 << exp_g));
        else pass_cnt++;
        n++;
      end
      if (grant_o === '0 && prev_grant !== '0) begin
        chk_cnt++;
        if (pkt_bytes != 2) $display("FAIL rr_pkt_len: got %0d bytes want 2", pkt_bytes);
        else pass_cnt++;
        pkt_bytes = 0;
      end
      fire = out_valid_o & out_ready_i;
      if (fire) begin
        chk_cnt++;
        if (out_data_o !== 8'(exp_g * 16 + bc[exp_g]))
          $display("FAIL rr_data: got %h want %h", out_data_o, 8'(exp_g * 16 + bc[exp_g]));
        else pass_cnt++;
        bc[exp_g] = (bc[exp_g] == 1) ? 0 : 1;
        pkt_bytes++;
      end
      prev_grant = grant_o;
    end
    chk_cnt++;
    if (n != 5) $display("FAIL rr_timeout: got %0d grants want 5", n);
    else pass_cnt++;
    $display("test_round_robin: %0d grants observed", n);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_no_interleave();
    do_reset();
    req_valid_i = 4'b0011;
    req_data_i[0 +: 8] = 8'hA0;
    req_data_i[8 +: 8] = 8'hB0;
    req_last_i  = 4'b0010;
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0000) $display("FAIL ni_pre_grant: got %b want 0000", grant_o);
    else pass_cnt++;

    next_cycle();
    #1;
    chk_cnt++;
    if ({grant_o, out_data_o} !== {4'b0001, 8'hA0})
      $display("FAIL ni_grant0: got grant=%b data=%h want 0001/a0", grant_o, out_data_o);
    else pass_cnt++;

    next_cycle();
    req_valid_i = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      #1;
      chk_cnt++;
      if ({grant_o, req_ready_o[1], out_valid_o} !== {4'b0001, 1'b0, 1'b0})
        $display("FAIL ni_hold%0d: got grant=%b ready1=%b valid=%b want 0001/0/0",
                 i, grant_o, req_ready_o[1], out_valid_o);
      else pass_cnt++;
    end

    next_cycle();
    req_valid_i = 4'b0011;
    req_data_i[0 +: 8] = 8'hA1;
    #1;
    chk_cnt++;
    if ({grant_o, out_data_o} !== {4'b0001, 8'hA1})
      $display("FAIL ni_resume: got grant=%b data=%h want 0001/a1", grant_o, out_data_o);
    else pass_cnt++;

    next_cycle();
    req_data_i[0 +: 8] = 8'hA2;
    req_last_i = 4'b0011;
    #1;
    chk_cnt++;
    if ({out_valid_o, out_data_o} !== {1'b1, 8'hA2})
      $display("FAIL ni_last: got valid=%b data=%h want 1/a2", out_valid_o, out_data_o);
    else pass_cnt++;

    next_cycle();
    req_valid_i = 4'b0010;
    #1;
    chk_cnt++;
    if ({grant_o, busy_o} !== 5'b0)
      $display("FAIL ni_release: got grant=%b busy=%b want 0000/0", grant_o, busy_o);
    else pass_cnt++;

    next_cycle();
    #1;
    chk_cnt++;
    if ({grant_o, out_data_o, req_ready_o} !== {4'b0010, 8'hB0, 4'b0010})
      $display("FAIL ni_grant1: got grant=%b data=%h ready=%b want 0010/b0/0010",
               grant_o, out_data_o, req_ready_o);
    else pass_cnt++;

    next_cycle();
    req_valid_i = '0;
    req_last_i  = '0;
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0000) $display("FAIL ni_end: got %b want 0000", grant_o);
    else pass_cnt++;
    $display("test_no_interleave: done");
  endtask

  // ---------------------------------------------------------------------------
  // Expected per cycle: {grant[3:0], busy, out_valid, out_data[7:0], req_ready[3:0]}
  task automatic test_backpressure_gap();
    logic [17:0] exp_tab [13];
    logic [3:0]  pat;
    logic [17:0] got;
    pat = 4'b1001;   // bit c%4 gives out_ready for cycle c: 1,0,0,1
    exp_tab[0]  = {4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    exp_tab[1]  = {4'h2, 1'b1, 1'b1, 8'h11, 4'h0};
    exp_tab[2]  = {4'h2, 1'b1, 1'b1, 8'h11, 4'h0};
    exp_tab[3]  = {4'h2, 1'b1, 1'b1, 8'h11, 4'h2};
    exp_tab[4]  = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[5]  = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[6]  = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[7]  = {4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    exp_tab[8]  = {4'h8, 1'b1, 1'b1, 8'h33, 4'h8};
    exp_tab[9]  = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[10] = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[11] = {4'h0, 1'b1, 1'b0, 8'h00, 4'h0};
    exp_tab[12] = {4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    do_reset();
    req_data_i[8  +: 8] = 8'h11;
    req_data_i[24 +: 8] = 8'h33;
    req_last_i = 4'b1010;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) next_cycle();
      out_ready_i    = pat[c % 4];
      req_valid_i[1] = (c <= 3);
      req_valid_i[3] = (c <= 8);
      // gap_i wiggles while the counter runs; the captured value must win
      gap_i = (c == 5 || c == 10) ? 16'd10 : 16'd3;
      #1;
      got = {grant_o, busy_o, out_valid_o, out_data_o, req_ready_o};
      chk_cnt++;
      if (got !== exp_tab[c])
        $display("FAIL bp_cycle%0d: got grant=%b busy=%b valid=%b data=%h ready=%b, want %h",
                 c, grant_o, busy_o, out_valid_o, out_data_o, req_ready_o, exp_tab[c]);
      else pass_cnt++;
    end
    clear_inputs();
    $display("test_backpressure_gap: done");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_packet();
    do_reset();
    req_valid_i = 4'b0001;
    req_data_i[0 +: 8] = 8'hC0;
    req_last_i = '0;
    next_cycle();
    #1;
    chk_cnt++;
    if ({grant_o, out_data_o} !== {4'b0001, 8'hC0})
      $display("FAIL rm_byte0: got grant=%b data=%h want 0001/c0", grant_o, out_data_o);
    else pass_cnt++;

    next_cycle();
    req_data_i[0 +: 8] = 8'hC1;
    #1;
    chk_cnt++;
    if ({out_valid_o, out_data_o} !== {1'b1, 8'hC1})
      $display("FAIL rm_byte1: got valid=%b data=%h want 1/c1", out_valid_o, out_data_o);
    else pass_cnt++;
    rst_n_i = 1'b0;
    #1;
    chk_cnt++;
    if ({grant_o, out_valid_o, req_ready_o, busy_o} !== 10'b0)
      $display("FAIL rm_async_clear: got grant=%b valid=%b ready=%b busy=%b want 0",
               grant_o, out_valid_o, req_ready_o, busy_o);
    else pass_cnt++;

    next_cycle();
    rst_n_i = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0000) $display("FAIL rm_after_release: got %b want 0000", grant_o);
    else pass_cnt++;

    next_cycle();
    #1;
    chk_cnt++;
    if (grant_o !== 4'b0001) $display("FAIL rm_first_winner: got %b want 0001", grant_o);
    else pass_cnt++;
    clear_inputs();
    $display("test_reset_mid_packet: done");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_no_interleave();
    test_backpressure_gap();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
